dmem_port_arbiter: RTL and testbench
====================================

# dmem_port_arbiter

Arbiter and sequencer for the single-port data memory. It shares that port between three requesters: the scalar core, the vector coprocessor's 4-lane load/store path, and the protocol controller's memory window. A vector request is unrolled into four back-to-back single-word accesses, and the four read lanes are returned together. The block sits between core/coprocessor/protocol controller and the datamem BRAM, and runs on the same clock as the core.

## Interface
- ADDR_BITS, 12, word-address width for all address ports
- DATA_WIDTH, 32, data word width
- clk  in  1  system clock; all logic on rising edge
- nrst  in  1  reset, asynchronous, active-low
- s_req  in  1  scalar access request; held until s_gnt
- s_we  in  4  scalar byte write enables; 0 means read
- s_addr  in  ADDR_BITS  scalar address
- s_wdata  in  DATA_WIDTH  scalar write data
- s_gnt  out  1  one-cycle grant; access issued this cycle
- s_rvalid  out  1  one-cycle; s_rdata valid
- s_rdata  out  DATA_WIDTH  scalar read data
- v_req  in  1  vector burst request (is_vltype | is_vstype); held until v_gnt
- v_we  in  1  1 = vector store (dm_v_write), full-word writes
- v_addr0..v_addr3  in  ADDR_BITS each  lane addresses
- v_wdata0..v_wdata3  in  DATA_WIDTH each  lane store data
- v_gnt  out  1  one-cycle burst acceptance
- v_done  out  1  one-cycle burst completion
- v_rdata0..v_rdata3  out  DATA_WIDTH each  lane load data, held until next v_done
- c_req, c_we[3:0], c_addr, c_wdata  in  protocol controller request; same semantics as scalar
- c_gnt, c_rvalid, c_rdata  out  same semantics as scalar
- mem_addr  out  ADDR_BITS  BRAM address
- mem_we  out  4  BRAM byte write enables
- mem_wdata  out  DATA_WIDTH  BRAM write data
- mem_rdata  in  DATA_WIDTH  BRAM read data; 1-cycle synchronous latency

## Operation
- FSM states are IDLE and VBURST. A 2-bit lane counter is active in VBURST.
- IDLE: each cycle, grant at most one requester by round-robin.
  - Order rotates to start after the last granted requester.
  - After reset the order is S, V, C.
  - A requester with req low is skipped.
- Scalar/con grant: gnt=1; mem_addr/we/wdata are driven combinationally from that requester's inputs in the grant cycle. The FSM stays in IDLE.
- Vector grant (cycle N):
  - v_gnt=1; lane 0 issues in cycle N directly from the inputs.
  - v_addr1..3 and v_wdata1..3 are registered at N. Inputs may change after N.
  - Go to VBURST with lane=1. Lanes 1, 2, 3 issue at N+1, N+2, N+3.
  - After lane 3 issues, return to IDLE.
- Vector write strobe: mem_we=4'hF when v_we=1, else 4'h0. The v_we value is latched at grant for lanes 1–3.
- Read return:
  - A registered tag records the issuing source and lane.
  - At cycle+1, mem_rdata is routed to s_rdata, c_rdata or v_rdata[lane].
  - s_rvalid/c_rvalid pulse only for reads (we==0); writes produce no rvalid.
- No grants are issued while in VBURST. Requests arriving then are arbitrated in the first IDLE cycle.
- When no access is issued: mem_we=0, mem_addr=0, mem_wdata=0.
- Requests may be withdrawn before grant, with no side effects. Address and data are sampled only in the grant cycle.

## Timing
- Reset values: all gnt/rvalid/done=0, all rdata=0, mem_*=0, FSM=IDLE, round-robin pointer selects S first.
- Scalar/con: grant at N, rvalid/rdata at N+1. Back-to-back grants are possible every cycle.
- Vector: v_gnt at N, lane k issued at N+k. v_done at N+4 for both loads and stores.
  - For loads, v_rdata0..3 all update by N+4 and are valid when v_done=1.
  - Earliest next grant of any kind is N+4.
- A scalar/con read return may overlap the cycle of the next grant; the return path is independent.
- Reset asserted mid-burst: the burst is aborted immediately.
  - No v_done is produced; remaining lanes are not issued.
  - mem_we drops to 0 asynchronously.
- A v_req still held after v_done is treated as a new burst and is subject to round-robin.

## Test plan
- Reset mid-burst: nrst low at N+2 of a vector store -> mem_we=0 immediately, no lane 2/3 write, no v_done; after release, a scalar read of the lane 2 address returns its old value.
- Scalar read: s_req, s_addr=0x010, memory holds 0xDEADBEEF -> s_gnt at N, mem_addr=0x010 at N, s_rvalid with s_rdata=0xDEADBEEF at N+1.
- Vector load: addrs 0x100..0x103 preloaded 1,2,3,4 -> v_gnt N, mem_addr 0x100..0x103 at N..N+3, v_done at N+4 with v_rdata0..3=1,2,3,4.
- Vector store with v_addr inputs changed at N+1: v_we=1, wdata A..D -> mem_we=4'hF for four cycles; the latched addresses are written, not the new inputs; v_done at N+4.
- All three requests held continuously from reset -> grant sequence S, V (4-cycle burst), C, S, V…; no requester starved; grants are one-hot per cycle.
- Con byte write: c_we=4'b0010, c_wdata=0x0000AB00 -> only byte 1 changes; no c_rvalid.

Source files
------------

// File: rtl/dmem_port_arbiter_if.sv
// Bundle of the three requester ports and the single-port BRAM bus around dmem_port_arbiter.
// The arbiter takes the slave view; the requesters and memory together take the master view.
interface dmem_port_arbiter_if #(
    parameter int ADDR_BITS  = 12,
    parameter int DATA_WIDTH = 32
);
    logic                  s_req;
    logic [3:0]            s_we;
    logic [ADDR_BITS-1:0]  s_addr;
    logic [DATA_WIDTH-1:0] s_wdata;
    logic                  s_gnt;
    logic                  s_rvalid;
    logic [DATA_WIDTH-1:0] s_rdata;

    logic                  v_req;
    logic                  v_we;
    logic [ADDR_BITS-1:0]  v_addr0, v_addr1, v_addr2, v_addr3;
    logic [DATA_WIDTH-1:0] v_wdata0, v_wdata1, v_wdata2, v_wdata3;
    logic                  v_gnt;
    logic                  v_done;
    logic [DATA_WIDTH-1:0] v_rdata0, v_rdata1, v_rdata2, v_rdata3;

    logic                  c_req;
    logic [3:0]            c_we;
    logic [ADDR_BITS-1:0]  c_addr;
    logic [DATA_WIDTH-1:0] c_wdata;
    logic                  c_gnt;
    logic                  c_rvalid;
    logic [DATA_WIDTH-1:0] c_rdata;

    logic [ADDR_BITS-1:0]  mem_addr;
    logic [3:0]            mem_we;
    logic [DATA_WIDTH-1:0] mem_wdata;
    logic [DATA_WIDTH-1:0] mem_rdata;

    modport slave (
        input  s_req, s_we, s_addr, s_wdata,
        output s_gnt, s_rvalid, s_rdata,
        input  v_req, v_we, v_addr0, v_addr1, v_addr2, v_addr3,
        input  v_wdata0, v_wdata1, v_wdata2, v_wdata3,
        output v_gnt, v_done, v_rdata0, v_rdata1, v_rdata2, v_rdata3,
        input  c_req, c_we, c_addr, c_wdata,
        output c_gnt, c_rvalid, c_rdata,
        output mem_addr, mem_we, mem_wdata,
        input  mem_rdata
    );

    modport master (
        output s_req, s_we, s_addr, s_wdata,
        input  s_gnt, s_rvalid, s_rdata,
        output v_req, v_we, v_addr0, v_addr1, v_addr2, v_addr3,
        output v_wdata0, v_wdata1, v_wdata2, v_wdata3,
        input  v_gnt, v_done, v_rdata0, v_rdata1, v_rdata2, v_rdata3,
        output c_req, c_we, c_addr, c_wdata,
        input  c_gnt, c_rvalid, c_rdata,
        input  mem_addr, mem_we, mem_wdata,
        output mem_rdata
    );
endinterface

// File: rtl/dmem_port_arbiter.sv
// Round-robin arbiter for the data memory port: scalar core, 4-lane vector path, protocol window.
// Vector bursts are unrolled into four consecutive single-word accesses.
//
// state  | meaning
// IDLE   | arbitrate; at most one grant per cycle (S/C single access, V lane 0)
// VBURST | issue vector lanes 1..3 from latched address/data; no grants
module dmem_port_arbiter #(
    parameter int ADDR_BITS  = 12,
    parameter int DATA_WIDTH = 32
) (
    input logic                clk,
    input logic                nrst,
    dmem_port_arbiter_if.slave bus
);
    typedef enum logic {IDLE = 1'b0, VBURST = 1'b1} state_t;

    localparam logic [1:0] SRC_S = 2'd0;
    localparam logic [1:0] SRC_V = 2'd1;
    localparam logic [1:0] SRC_C = 2'd2;

    state_t                state, state_nxt;
    logic [1:0]            lane;
    logic [1:0]            last_src;
    logic                  gnt_s, gnt_v, gnt_c;

    logic [ADDR_BITS-1:0]  lat_addr1, lat_addr2, lat_addr3;
    logic [DATA_WIDTH-1:0] lat_wdata1, lat_wdata2, lat_wdata3;
    logic                  lat_we;

    logic                  iss_valid, iss_rd;
    logic [1:0]            iss_src, iss_lane;
    logic                  tag_valid, tag_rd;
    logic [1:0]            tag_src, tag_lane;

    logic [DATA_WIDTH-1:0] stage0, stage1, stage2;
    logic [DATA_WIDTH-1:0] hold0, hold1, hold2, hold3;
    logic                  s_ret, c_ret, v_fin, v_fin_rd;

    always_ff @(posedge clk or negedge nrst) begin
        if (!nrst) state <= IDLE;
        else       state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (gnt_v) state_nxt = VBURST;
            VBURST:  if (lane == 2'd3) state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    // Grants are held off while reset is asserted so the memory port is quiet immediately.
    always_comb begin
        gnt_s = 1'b0;
        gnt_v = 1'b0;
        gnt_c = 1'b0;
        if (nrst && state == IDLE) begin
            case (last_src)
                SRC_S: begin
                    if (bus.v_req)      gnt_v = 1'b1;
                    else if (bus.c_req) gnt_c = 1'b1;
                    else if (bus.s_req) gnt_s = 1'b1;
                end
                SRC_V: begin
                    if (bus.c_req)      gnt_c = 1'b1;
                    else if (bus.s_req) gnt_s = 1'b1;
                    else if (bus.v_req) gnt_v = 1'b1;
                end
                default: begin
                    if (bus.s_req)      gnt_s = 1'b1;
                    else if (bus.v_req) gnt_v = 1'b1;
                    else if (bus.c_req) gnt_c = 1'b1;
                end
            endcase
        end

        bus.mem_addr  = '0;
        bus.mem_we    = '0;
        bus.mem_wdata = '0;
        iss_valid     = 1'b0;
        iss_rd        = 1'b0;
        iss_src       = SRC_S;
        iss_lane      = 2'd0;
        if (gnt_s) begin
            bus.mem_addr  = bus.s_addr;
            bus.mem_we    = bus.s_we;
            bus.mem_wdata = bus.s_wdata;
            iss_valid     = 1'b1;
            iss_rd        = (bus.s_we == 4'h0);
        end else if (gnt_c) begin
            bus.mem_addr  = bus.c_addr;
            bus.mem_we    = bus.c_we;
            bus.mem_wdata = bus.c_wdata;
            iss_valid     = 1'b1;
            iss_rd        = (bus.c_we == 4'h0);
            iss_src       = SRC_C;
        end else if (gnt_v) begin
            bus.mem_addr  = bus.v_addr0;
            bus.mem_we    = {4{bus.v_we}};
            bus.mem_wdata = bus.v_wdata0;
            iss_valid     = 1'b1;
            iss_rd        = !bus.v_we;
            iss_src       = SRC_V;
        end else if (state == VBURST) begin
            case (lane)
                2'd1: begin
                    bus.mem_addr  = lat_addr1;
                    bus.mem_wdata = lat_wdata1;
                end
                2'd2: begin
                    bus.mem_addr  = lat_addr2;
                    bus.mem_wdata = lat_wdata2;
                end
                default: begin
                    bus.mem_addr  = lat_addr3;
                    bus.mem_wdata = lat_wdata3;
                end
            endcase
            bus.mem_we = {4{lat_we}};
            iss_valid  = 1'b1;
            iss_rd     = !lat_we;
            iss_src    = SRC_V;
            iss_lane   = lane;
        end
    end

    always_ff @(posedge clk or negedge nrst) begin
        if (!nrst) begin
            lane       <= 2'd0;
            last_src   <= SRC_C;
            lat_addr1  <= '0;
            lat_addr2  <= '0;
            lat_addr3  <= '0;
            lat_wdata1 <= '0;
            lat_wdata2 <= '0;
            lat_wdata3 <= '0;
            lat_we     <= 1'b0;
        end else begin
            if (gnt_s)      last_src <= SRC_S;
            else if (gnt_v) last_src <= SRC_V;
            else if (gnt_c) last_src <= SRC_C;

            if (gnt_v) begin
                lane       <= 2'd1;
                lat_addr1  <= bus.v_addr1;
                lat_addr2  <= bus.v_addr2;
                lat_addr3  <= bus.v_addr3;
                lat_wdata1 <= bus.v_wdata1;
                lat_wdata2 <= bus.v_wdata2;
                lat_wdata3 <= bus.v_wdata3;
                lat_we     <= bus.v_we;
            end else if (state == VBURST) begin
                lane <= lane + 2'd1;
            end
        end
    end

    // The tag follows each access by one cycle, matching the BRAM read latency.
    always_ff @(posedge clk or negedge nrst) begin
        if (!nrst) begin
            tag_valid <= 1'b0;
            tag_rd    <= 1'b0;
            tag_src   <= SRC_S;
            tag_lane  <= 2'd0;
        end else begin
            tag_valid <= iss_valid;
            tag_rd    <= iss_rd;
            tag_src   <= iss_src;
            tag_lane  <= iss_lane;
        end
    end

    // Lanes 0..2 are staged so the visible vector result only changes on v_done.
    always_ff @(posedge clk or negedge nrst) begin
        if (!nrst) begin
            stage0 <= '0;
            stage1 <= '0;
            stage2 <= '0;
            hold0  <= '0;
            hold1  <= '0;
            hold2  <= '0;
            hold3  <= '0;
        end else if (tag_valid && tag_rd && tag_src == SRC_V) begin
            case (tag_lane)
                2'd0: stage0 <= bus.mem_rdata;
                2'd1: stage1 <= bus.mem_rdata;
                2'd2: stage2 <= bus.mem_rdata;
                default: begin
                    hold0 <= stage0;
                    hold1 <= stage1;
                    hold2 <= stage2;
                    hold3 <= bus.mem_rdata;
                end
            endcase
        end
    end

    assign s_ret    = tag_valid && tag_rd && (tag_src == SRC_S);
    assign c_ret    = tag_valid && tag_rd && (tag_src == SRC_C);
    assign v_fin    = tag_valid && (tag_src == SRC_V) && (tag_lane == 2'd3);
    assign v_fin_rd = v_fin && tag_rd;

    assign bus.s_gnt    = gnt_s;
    assign bus.c_gnt    = gnt_c;
    assign bus.v_gnt    = gnt_v;
    assign bus.s_rvalid = s_ret;
    assign bus.c_rvalid = c_ret;
    assign bus.s_rdata  = s_ret ? bus.mem_rdata : '0;
    assign bus.c_rdata  = c_ret ? bus.mem_rdata : '0;
    assign bus.v_done   = v_fin;
    assign bus.v_rdata0 = v_fin_rd ? stage0 : hold0;
    assign bus.v_rdata1 = v_fin_rd ? stage1 : hold1;
    assign bus.v_rdata2 = v_fin_rd ? stage2 : hold2;
    assign bus.v_rdata3 = v_fin_rd ? bus.mem_rdata : hold3;
endmodule

// File: tb/tb_dmem_port_arbiter.sv
// Bench for dmem_port_arbiter: table-driven single accesses, hand-written burst/reset/fairness
// sequences, and a randomized phase checked against an abstract arbitration and memory model.
`timescale 1ns/1ps
module tb_dmem_port_arbiter;
    localparam int AW = 12;
    localparam int DW = 32;

    logic clk = 1'b0;
    logic nrst = 1'b0;
    always #5 clk = ~clk;

    dmem_port_arbiter_if #(.ADDR_BITS(AW), .DATA_WIDTH(DW)) bus ();
    dmem_port_arbiter #(.ADDR_BITS(AW), .DATA_WIDTH(DW)) dut (.clk(clk), .nrst(nrst), .bus(bus));

    logic [DW-1:0] bram [0:(1<<AW)-1] = '{default: '0};
    always @(posedge clk) begin
        for (int b = 0; b < 4; b++)
            if (bus.mem_we[b]) bram[bus.mem_addr][8*b +: 8] <= bus.mem_wdata[8*b +: 8];
        bus.mem_rdata <= bram[bus.mem_addr];
    end

    int total = 0;
    int bad = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic idle_reqs();
        bus.s_req = 0; bus.s_we = 0; bus.s_addr = 0; bus.s_wdata = 0;
        bus.c_req = 0; bus.c_we = 0; bus.c_addr = 0; bus.c_wdata = 0;
        bus.v_req = 0; bus.v_we = 0;
        bus.v_addr0 = 0; bus.v_addr1 = 0; bus.v_addr2 = 0; bus.v_addr3 = 0;
        bus.v_wdata0 = 0; bus.v_wdata1 = 0; bus.v_wdata2 = 0; bus.v_wdata3 = 0;
    endtask

    typedef struct {
        bit        con;
        logic [3:0] we;
        logic [11:0] addr;
        logic [31:0] wdata;
        logic [31:0] exp;
    } vec_t;

    task automatic single(input vec_t t, input string tag);
        @(negedge clk);
        if (t.con) begin
            bus.c_req = 1; bus.c_we = t.we; bus.c_addr = t.addr; bus.c_wdata = t.wdata;
        end else begin
            bus.s_req = 1; bus.s_we = t.we; bus.s_addr = t.addr; bus.s_wdata = t.wdata;
        end
        #2;
        check({tag, " gnt"}, t.con ? bus.c_gnt : bus.s_gnt, 1);
        check({tag, " mem_addr"}, bus.mem_addr, t.addr);
        check({tag, " mem_we"}, bus.mem_we, t.we);
        @(negedge clk);
        idle_reqs();
        #2;
        check({tag, " rvalid"}, t.con ? bus.c_rvalid : bus.s_rvalid, (t.we == 4'h0));
        if (t.we == 4'h0) check({tag, " rdata"}, t.con ? bus.c_rdata : bus.s_rdata, t.exp);
    endtask

    function automatic int gnt_code();
        return bus.s_gnt ? 1 : bus.v_gnt ? 2 : bus.c_gnt ? 3 : 0;
    endfunction

    vec_t vecs[17];
    int   exp_seq[12] = '{1, 2, 0, 0, 0, 3, 1, 2, 0, 0, 0, 3};

    // randomized-phase model state
    bit          pend[3];
    logic [3:0]  pwe[3];
    int          pidx[3][4];
    logic [31:0] pwd[3][4];
    bit          pvwe;
    logic [31:0] rmem[16];
    int          last_g, busy, vdone_in, g;
    bit          exp_srv, exp_crv, vload;
    logic [31:0] exp_sd, exp_cd;
    logic [31:0] vexp[4];

    initial begin
        vecs[0]  = '{0, 4'hF, 12'h010, 32'hDEADBEEF, 32'h0};
        vecs[1]  = '{0, 4'h0, 12'h010, 32'h0, 32'hDEADBEEF};
        vecs[2]  = '{1, 4'hF, 12'h020, 32'h11223344, 32'h0};
        vecs[3]  = '{1, 4'h2, 12'h020, 32'h0000AB00, 32'h0};
        vecs[4]  = '{1, 4'h0, 12'h020, 32'h0, 32'h1122AB44};
        vecs[5]  = '{0, 4'h0, 12'h020, 32'h0, 32'h1122AB44};
        vecs[6]  = '{0, 4'h8, 12'h010, 32'hAA000000, 32'h0};
        vecs[7]  = '{1, 4'h0, 12'h010, 32'h0, 32'hAAADBEEF};
        vecs[8]  = '{0, 4'hF, 12'h100, 32'd1, 32'h0};
        vecs[9]  = '{0, 4'hF, 12'h101, 32'd2, 32'h0};
        vecs[10] = '{1, 4'hF, 12'h102, 32'd3, 32'h0};
        vecs[11] = '{1, 4'hF, 12'h103, 32'd4, 32'h0};
        vecs[12] = '{0, 4'hF, 12'h200, 32'h5000, 32'h0};
        vecs[13] = '{0, 4'hF, 12'h201, 32'h5001, 32'h0};
        vecs[14] = '{1, 4'hF, 12'h202, 32'h5002, 32'h0};
        vecs[15] = '{1, 4'hF, 12'h203, 32'h5003, 32'h0};
        vecs[16] = '{0, 4'h0, 12'hFFF, 32'h0, 32'h0};

        // reset values, with a scalar request pending to show grants stay low
        idle_reqs();
        bus.s_req = 1; bus.s_we = 4'hF; bus.s_addr = 12'h055;
        #12;
        check("rst s_gnt", bus.s_gnt, 0);
        check("rst mem_we", bus.mem_we, 0);
        check("rst mem_addr", bus.mem_addr, 0);
        check("rst rvalid/done", {bus.s_rvalid, bus.c_rvalid, bus.v_done, bus.v_gnt}, 0);
        check("rst v_rdata0", bus.v_rdata0, 0);
        idle_reqs();
        @(negedge clk);
        nrst = 1;

        for (int i = 0; i < 17; i++) single(vecs[i], $sformatf("vec%0d", i));

        // vector load, input addresses scrambled after grant
        @(negedge clk);
        bus.v_req = 1; bus.v_we = 0;
        bus.v_addr0 = 12'h100; bus.v_addr1 = 12'h101; bus.v_addr2 = 12'h102; bus.v_addr3 = 12'h103;
        #2;
        check("vld gnt", bus.v_gnt, 1);
        check("vld lane0 addr", bus.mem_addr, 12'h100);
        check("vld lane0 we", bus.mem_we, 0);
        for (int k = 1; k < 4; k++) begin
            @(negedge clk);
            idle_reqs();
            bus.v_addr1 = 12'h7F1; bus.v_addr2 = 12'h7F2; bus.v_addr3 = 12'h7F3;
            bus.s_req = 1; bus.s_addr = 12'h010;
            #2;
            check($sformatf("vld lane%0d addr", k), bus.mem_addr, 12'h100 + 12'(k));
            check($sformatf("vld lane%0d quiet", k), {bus.s_gnt, bus.v_gnt, bus.c_gnt, bus.v_done}, 0);
        end
        @(negedge clk);
        idle_reqs();
        #2;
        check("vld done", bus.v_done, 1);
        check("vld rdata", {bus.v_rdata0, bus.v_rdata1}, {32'd1, 32'd2});
        check("vld rdata hi", {bus.v_rdata2, bus.v_rdata3}, {32'd3, 32'd4});
        @(negedge clk);
        #2;
        check("vld done pulse", bus.v_done, 0);
        check("vld held", {bus.v_rdata0, bus.v_rdata3}, {32'd1, 32'd4});

        // vector store, inputs changed after grant
        @(negedge clk);
        bus.v_req = 1; bus.v_we = 1;
        bus.v_addr0 = 12'h180; bus.v_addr1 = 12'h181; bus.v_addr2 = 12'h182; bus.v_addr3 = 12'h183;
        bus.v_wdata0 = 32'hAAAA0000; bus.v_wdata1 = 32'hBBBB0001;
        bus.v_wdata2 = 32'hCCCC0002; bus.v_wdata3 = 32'hDDDD0003;
        #2;
        check("vst gnt", bus.v_gnt, 1);
        check("vst lane0", {bus.mem_we, bus.mem_addr, bus.mem_wdata}, {4'hF, 12'h180, 32'hAAAA0000});
        for (int k = 1; k < 4; k++) begin
            @(negedge clk);
            bus.v_req = 0;
            bus.v_addr1 = 12'h1C1; bus.v_addr2 = 12'h1C2; bus.v_addr3 = 12'h1C3;
            bus.v_wdata1 = 0; bus.v_wdata2 = 0; bus.v_wdata3 = 0;
            #2;
            check($sformatf("vst lane%0d", k), {bus.mem_we, bus.mem_addr},
                  {4'hF, 12'h180 + 12'(k)});
        end
        @(negedge clk);
        idle_reqs();
        #2;
        check("vst done", bus.v_done, 1);
        check("vst rdata kept", bus.v_rdata2, 32'd3);
        single('{0, 4'h0, 12'h181, 32'h0, 32'hBBBB0001}, "vst rb1");
        single('{1, 4'h0, 12'h183, 32'h0, 32'hDDDD0003}, "vst rb3");
        single('{0, 4'h0, 12'h1C2, 32'h0, 32'h0}, "vst new addr untouched");

        // reset during a vector store at lane 2
        @(negedge clk);
        bus.v_req = 1; bus.v_we = 1;
        bus.v_addr0 = 12'h200; bus.v_addr1 = 12'h201; bus.v_addr2 = 12'h202; bus.v_addr3 = 12'h203;
        bus.v_wdata0 = 32'hBAD00000; bus.v_wdata1 = 32'hBAD00001;
        bus.v_wdata2 = 32'hBAD00002; bus.v_wdata3 = 32'hBAD00003;
        #2;
        check("abort gnt", bus.v_gnt, 1);
        @(negedge clk);
        idle_reqs();
        #2;
        check("abort lane1", {bus.mem_we, bus.mem_addr}, {4'hF, 12'h201});
        @(negedge clk);
        #2;
        nrst = 0;
        #1;
        check("abort mem_we", bus.mem_we, 0);
        check("abort mem_addr", bus.mem_addr, 0);
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            #2;
            check($sformatf("abort no done %0d", k), {bus.v_done, bus.mem_we}, 0);
        end
        @(negedge clk);
        nrst = 1;
        single('{0, 4'h0, 12'h202, 32'h0, 32'h5002}, "abort lane2 old");
        single('{0, 4'h0, 12'h203, 32'h0, 32'h5003}, "abort lane3 old");
        single('{1, 4'h0, 12'h201, 32'h0, 32'hBAD00001}, "abort lane1 written");

        // all three requesters held from reset
        @(negedge clk);
        nrst = 0;
        bus.s_req = 1; bus.s_addr = 12'h010;
        bus.c_req = 1; bus.c_addr = 12'h020;
        bus.v_req = 1; bus.v_addr0 = 12'h100; bus.v_addr1 = 12'h101;
        bus.v_addr2 = 12'h102; bus.v_addr3 = 12'h103;
        @(negedge clk);
        nrst = 1;
        for (int i = 0; i < 12; i++) begin
            #2;
            check($sformatf("rr onehot %0d", i), $countones({bus.s_gnt, bus.v_gnt, bus.c_gnt}) <= 1, 1);
            check($sformatf("rr seq %0d", i), gnt_code(), exp_seq[i]);
            @(negedge clk);
        end
        idle_reqs();
        repeat (5) @(negedge clk);

        // randomized traffic in 0x300..0x30F against an abstract model
        nrst = 0;
        @(negedge clk);
        nrst = 1;
        for (int i = 0; i < 16; i++) rmem[i] = 0;
        for (int r = 0; r < 3; r++) pend[r] = 0;
        last_g = 2; busy = 0; vdone_in = 0; exp_srv = 0; exp_crv = 0; vload = 0;
        exp_sd = 0; exp_cd = 0;
        for (int cyc = 0; cyc < 800; cyc++) begin
            @(negedge clk);
            for (int r = 0; r < 3; r++) begin
                if (!pend[r] && $urandom_range(0, 2) == 0) begin
                    pend[r] = 1;
                    pwe[r] = ($urandom_range(0, 1) == 0) ? 4'h0 : 4'($urandom_range(1, 15));
                    for (int l = 0; l < 4; l++) begin
                        pidx[r][l] = $urandom_range(0, 15);
                        pwd[r][l] = $urandom;
                    end
                    if (r == 1) pvwe = 1'($urandom_range(0, 1));
                end else if (pend[r] && $urandom_range(0, 19) == 0) begin
                    pend[r] = 0;
                end
            end
            bus.s_req = pend[0]; bus.s_we = pwe[0];
            bus.s_addr = 12'h300 + 12'(pidx[0][0]); bus.s_wdata = pwd[0][0];
            bus.c_req = pend[2]; bus.c_we = pwe[2];
            bus.c_addr = 12'h300 + 12'(pidx[2][0]); bus.c_wdata = pwd[2][0];
            bus.v_req = pend[1]; bus.v_we = pvwe;
            bus.v_addr0 = 12'h300 + 12'(pidx[1][0]); bus.v_addr1 = 12'h300 + 12'(pidx[1][1]);
            bus.v_addr2 = 12'h300 + 12'(pidx[1][2]); bus.v_addr3 = 12'h300 + 12'(pidx[1][3]);
            bus.v_wdata0 = pwd[1][0]; bus.v_wdata1 = pwd[1][1];
            bus.v_wdata2 = pwd[1][2]; bus.v_wdata3 = pwd[1][3];
            #2;
            g = -1;
            if (busy == 0)
                for (int k = 1; k <= 3; k++)
                    if (g < 0 && pend[(last_g + k) % 3]) g = (last_g + k) % 3;
            check($sformatf("rnd gnt c%0d", cyc), {bus.c_gnt, bus.v_gnt, bus.s_gnt},
                  (g < 0) ? 3'b000 : 3'(1 << g));
            if (g >= 0)
                check($sformatf("rnd addr c%0d", cyc), bus.mem_addr, 12'h300 + 12'(pidx[g][0]));
            check($sformatf("rnd s_rvalid c%0d", cyc), bus.s_rvalid, exp_srv);
            if (exp_srv) check($sformatf("rnd s_rdata c%0d", cyc), bus.s_rdata, exp_sd);
            check($sformatf("rnd c_rvalid c%0d", cyc), bus.c_rvalid, exp_crv);
            if (exp_crv) check($sformatf("rnd c_rdata c%0d", cyc), bus.c_rdata, exp_cd);
            check($sformatf("rnd v_done c%0d", cyc), bus.v_done, (vdone_in == 1));
            if (vdone_in == 1 && vload) begin
                check($sformatf("rnd v_rdata01 c%0d", cyc), {bus.v_rdata0, bus.v_rdata1}, {vexp[0], vexp[1]});
                check($sformatf("rnd v_rdata23 c%0d", cyc), {bus.v_rdata2, bus.v_rdata3}, {vexp[2], vexp[3]});
            end
            exp_srv = 0; exp_crv = 0;
            if (busy > 0) busy--;
            if (vdone_in > 0) vdone_in--;
            if (g >= 0) begin
                last_g = g;
                pend[g] = 0;
                if (g == 1) begin
                    busy = 3; vdone_in = 4; vload = !pvwe;
                    for (int l = 0; l < 4; l++) begin
                        if (pvwe) rmem[pidx[1][l]] = pwd[1][l];
                        else vexp[l] = rmem[pidx[1][l]];
                    end
                end else if (pwe[g] == 4'h0) begin
                    if (g == 0) begin exp_srv = 1; exp_sd = rmem[pidx[0][0]]; end
                    else begin exp_crv = 1; exp_cd = rmem[pidx[2][0]]; end
                end else begin
                    for (int b = 0; b < 4; b++)
                        if (pwe[g][b]) rmem[pidx[g][0]][8*b +: 8] = pwd[g][0][8*b +: 8];
                end
            end
        end
        idle_reqs();
        repeat (6) @(negedge clk);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
